smallpipe_sprite_fetch: RTL
===========================

Name: smallpipe_sprite_fetch

Overview:
Upstream feeder of the small-pipe colour palette. It tracks the scrolling position and gap height of one small pipe pair, and maps the VGA controller's DrawX/DrawY to a sprite-ROM address. It registers the returned 4-bit palette index, which goes to the palette stage together with a pixel-valid flag. Transparent index 4'h8 never asserts the flag.

Parameters:
SCREEN_W, 640, visible width; pipe re-enters at this x
PIPE_W, 32, sprite width in pixels (power of 2)
SPRITE_H, 64, sprite rows; the last row repeats as the pipe body
GAP_H, 128, vertical opening height
GAP_MIN, 64, minimum gap top y
SPEED, 2, pixels moved per frame
TRANSP_IDX, 4'h8, colour-key index
LFSR_SEED, 8'hA5, LFSR reset value

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high
frame_clk  in  1  vsync level; rising edge = frame tick
start  in  1  start/restart scrolling (pulse)
stop  in  1  freeze, e.g. on collision (pulse)
DrawX  in  10  current pixel x
DrawY  in  10  current pixel y
rom_addr  out  11  sprite ROM address, row*PIPE_W+col
rom_q  in  4  ROM data, valid one Clk after rom_addr
spipe_index  out  4  palette index to the colour palette stage
spipe_on  out  1  pipe pixel present and opaque
pipe_x  out  11  signed left edge of the pipe
gap_y  out  10  gap top y
running  out  1  state == RUN

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high.
- Reset values:
  - state=IDLE, pipe_x=SCREEN_W, lfsr=LFSR_SEED
  - gap_y=GAP_MIN+LFSR_SEED[6:0], which is 101 at defaults
  - rom_addr=0, spipe_index=TRANSP_IDX, spipe_on=0
  - frame_clk_d=1, so no spurious tick is generated after reset
- Frame tick: tick = frame_clk & ~frame_clk_d. Tick is a single-Clk pulse.
- FSM states: IDLE, RUN, FROZEN.
  - IDLE: start -> RUN.
  - RUN: stop -> FROZEN.
  - FROZEN: start -> RUN, reloading pipe_x=SCREEN_W and keeping gap_y.
  - If start and stop arrive in the same cycle, stop wins.
  - If start and tick coincide, the state changes and there is no movement that frame.
- Motion: only in RUN, on tick.
  - Normally nx = pipe_x - SPEED.
  - If nx <= -PIPE_W: pipe_x <= SCREEN_W, the LFSR steps once, and gap_y <= GAP_MIN + next_lfsr[6:0].
  - Wrap and reload happen in the same cycle.
- LFSR: 8-bit Fibonacci shift-left, new bit0 = l7^l5^l4^l3. It only steps on wrap. From A5 the next value is 4A.
- Hit test (stage 1):
  - col = DrawX - pipe_x, valid when 0 <= col < PIPE_W.
  - Top pipe when DrawY < gap_y: dy = gap_y-1-DrawY (mirrored).
  - Bottom pipe when DrawY >= gap_y+GAP_H: dy = DrawY-(gap_y+GAP_H).
  - row = min(dy, SPRITE_H-1).
  - Registered outputs: rom_addr and hit_d1. On a miss, rom_addr holds 0 and hit_d1=0.
- Stage 2: spipe_index <= hit_d1 ? rom_q : TRANSP_IDX, and spipe_on <= hit_d1 & (rom_q != TRANSP_IDX).
- Latency: DrawX/DrawY to spipe_index/spipe_on is exactly 2 Clk, regardless of state. Fetch runs even in IDLE/FROZEN so a frozen pipe stays drawn.
- Width rules: pipe_x and col use signed 11-bit arithmetic. Compare against 0 and PIPE_W before truncating col to log2(PIPE_W) bits.
- Pipeline update order: pipe_x/gap_y changes take effect for the next pixel. There is no frame-boundary double buffering; the update lands during vsync.
- Reset mid-frame: the pipeline flushes to reset values on the next edge.

Optional Feature:
Macro SMALLPIPE_SCORE_EN.
- Defined:
  - Adds parameter BIRD_X (default 160) and output score_pulse.
  - score_pulse is a 1-Clk pulse on the tick where pipe_x+PIPE_W crosses from >= BIRD_X to < BIRD_X while in RUN.
  - It fires at most once per pass and is cleared by Reset.
- Undefined: no port and no logic.

Decomposition:
- Package smallpipe_pkg holds:
  - pipe_state_t enum (IDLE, RUN, FROZEN)
  - TRANSP_IDX
  - the LFSR tap constants
  - the screen-dimension constants shared with the palette stage
- Sub-module pipe_lfsr8: seedable 8-bit LFSR with step enable. The top level instantiates it once.

Test Plan:
- Reset: state and outputs -> pipe_x=640, gap_y=101, spipe_index=8, spipe_on=0; frame_clk held high through reset -> no tick.
- start, then 3 ticks -> pipe_x=634; stop, then 2 ticks -> pipe_x stays 634 and running=0.
- Force pipe_x=-30 in RUN, tick -> pipe_x=640, gap_y=138 (LFSR 4A).
- pipe_x=100, gap_y=101, DrawX=105, DrawY=232 -> next cycle rom_addr=101; rom_q=2 -> following cycle spipe_index=2, spipe_on=1.
- DrawY=100, DrawX=100 -> rom_addr=0 (top row 0); rom_q=8 -> spipe_on=0. DrawY=180 (inside gap) -> spipe_on=0, spipe_index=8.
- start and stop asserted together in IDLE -> remains IDLE; in RUN -> FROZEN.

Source files
------------

// File: rtl/smallpipe_sprite_fetch_pkg.sv
// Shared types and constants for the small-pipe sprite fetch and the palette stage that follows it.
package smallpipe_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } pipe_state_t;

    localparam logic [3:0] TRANSP_IDX = 4'h8;

    // Feedback taps l7, l5, l4, l3 of the 8-bit Fibonacci gap generator
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;

endpackage

// File: rtl/smallpipe_sprite_fetch_lfsr.sv
// Seedable 8-bit shift-left Fibonacci LFSR that advances only when step is high.
module pipe_lfsr8
    import smallpipe_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
)(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       step,
    output logic [7:0] q
);

    logic feedback;

    assign feedback = ^(q & LFSR_TAPS);

    always_ff @(posedge Clk) begin
        if (Reset)
            q <= SEED;
        else if (step)
            q <= {q[6:0], feedback};
    end

endmodule

// File: rtl/smallpipe_sprite_fetch.sv
// Scrolls one small pipe pair and turns DrawX/DrawY into a 2-stage sprite fetch for the palette.
// Optional score output is enabled with the SMALLPIPE_SCORE_EN macro.
module smallpipe_sprite_fetch
    import smallpipe_pkg::*;
#(
    parameter int         SCREEN_W  = SCREEN_WIDTH,
    parameter int         PIPE_W    = 32,
    parameter int         SPRITE_H  = 64,
    parameter int         GAP_H     = 128,
    parameter int         GAP_MIN   = 64,
    parameter int         SPEED     = 2,
    parameter logic [7:0] LFSR_SEED = 8'hA5
`ifdef SMALLPIPE_SCORE_EN
    ,
    parameter int         BIRD_X    = 160
`endif
)(
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic               start,
    input  logic               stop,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    output logic [10:0]        rom_addr,
    input  logic [3:0]         rom_q,
    output logic [3:0]         spipe_index,
    output logic               spipe_on,
    output logic signed [10:0] pipe_x,
    output logic [9:0]         gap_y,
    output logic               running
`ifdef SMALLPIPE_SCORE_EN
    ,
    output logic               score_pulse
`endif
);

    localparam int COL_W  = $clog2(PIPE_W);
    localparam int ROW_W  = $clog2(SPRITE_H);
    localparam int ADDR_W = 11;

    localparam logic signed [10:0] X_RELOAD = 11'(SCREEN_W);
    localparam logic signed [10:0] WRAP_X   = 11'(-PIPE_W);
    localparam logic signed [10:0] PIPE_W_S = 11'(PIPE_W);
    localparam logic signed [10:0] STEP_S   = 11'(SPEED);
    localparam logic [9:0]         GAP_MIN_V = 10'(GAP_MIN);
    localparam logic [9:0]         GAP_H_V   = 10'(GAP_H);
    localparam logic [9:0]         ROW_MAX_V = 10'(SPRITE_H - 1);

    pipe_state_t        state, next_state;
    logic               frame_clk_d;
    logic               tick, move, wrap, reload;
    logic signed [10:0] nx;
    logic [7:0]         lfsr_q;
    logic               lfsr_unused;

    logic signed [10:0] col;
    logic               col_hit, top_hit, bot_hit, pix_hit, hit_d1;
    logic [9:0]         bot_start, dy;
    logic [ROW_W-1:0]   row;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start && !stop) next_state = RUN;
            RUN:     if (stop)           next_state = FROZEN;
            FROZEN:  if (start && !stop) next_state = RUN;
            default:                     next_state = IDLE;
        endcase
    end

    assign tick    = frame_clk & ~frame_clk_d;
    assign nx      = pipe_x - STEP_S;
    // A frame whose tick coincides with a state change does not move the pipe
    assign move    = (state == RUN) && (next_state == RUN) && tick;
    assign wrap    = move && (nx <= WRAP_X);
    assign reload  = (state == FROZEN) && (next_state == RUN);
    assign running = (state == RUN);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            frame_clk_d <= 1'b1;
            pipe_x      <= X_RELOAD;
        end else begin
            state       <= next_state;
            frame_clk_d <= frame_clk;
            if (reload || wrap)
                pipe_x <= X_RELOAD;
            else if (move)
                pipe_x <= nx;
        end
    end

    pipe_lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .step  (wrap),
        .q     (lfsr_q)
    );

    // The LFSR steps only on wrap, so its current value is always the active gap seed
    assign gap_y       = GAP_MIN_V + {3'b000, lfsr_q[6:0]};
    assign lfsr_unused = lfsr_q[7];

    always_comb begin
        col       = $signed({1'b0, DrawX}) - pipe_x;
        col_hit   = (col >= 11'sd0) && (col < PIPE_W_S);
        bot_start = gap_y + GAP_H_V;
        top_hit   = DrawY < gap_y;
        bot_hit   = DrawY >= bot_start;
        dy        = top_hit ? (gap_y - 10'd1 - DrawY) : (DrawY - bot_start);
        row       = (dy > ROW_MAX_V) ? ROW_MAX_V[ROW_W-1:0] : dy[ROW_W-1:0];
        pix_hit   = col_hit && (top_hit || bot_hit);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr    <= '0;
            hit_d1      <= 1'b0;
            spipe_index <= TRANSP_IDX;
            spipe_on    <= 1'b0;
        end else begin
            rom_addr    <= pix_hit ? ADDR_W'({row, col[COL_W-1:0]}) : '0;
            hit_d1      <= pix_hit;
            spipe_index <= hit_d1 ? rom_q : TRANSP_IDX;
            spipe_on    <= hit_d1 && (rom_q != TRANSP_IDX);
        end
    end

`ifdef SMALLPIPE_SCORE_EN
    localparam logic signed [10:0] BIRD_X_S = 11'(BIRD_X);

    logic               scored;
    logic signed [10:0] right_now, right_next;

    assign right_now  = pipe_x + PIPE_W_S;
    assign right_next = nx + PIPE_W_S;

    // scored blocks a second pulse until the pipe re-enters from the right
    always_ff @(posedge Clk) begin
        if (Reset) begin
            score_pulse <= 1'b0;
            scored      <= 1'b0;
        end else begin
            score_pulse <= 1'b0;
            if (reload || wrap) begin
                scored <= 1'b0;
            end else if (move && !scored && (right_now >= BIRD_X_S) && (right_next < BIRD_X_S)) begin
                score_pulse <= 1'b1;
                scored      <= 1'b1;
            end
        end
    end
`endif

endmodule
